regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port among several writeback requesters: ALU result, memory load return, and host/debug poke. Each requester gets a one-entry holding slot behind a valid/ready handshake. A round-robin arbiter drains one slot per cycle into registered WriteAddr/WriteData/WriteEnable outputs that drive the register file directly. A PendingMask tells decode which registers still have writes in flight.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = debug.
- DATA_W, 16, register width.
- ADDR_W, 4, register address width (16 registers, r0 hardwired zero).
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset Reset, synchronous, active-high.
- ReqValid  in  NUM_REQ  per-requester write request.
- ReqAddr  in  NUM_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W].
- ReqData  in  NUM_REQ*DATA_W  write data, same packing.
- ReqReady  out  NUM_REQ  slot i can accept this cycle.
- WriteEnable  out  1  registered write strobe to the register file.
- WriteAddr  out  ADDR_W  registered write address.
- WriteData  out  DATA_W  registered write data.
- Grant  out  NUM_REQ  registered one-hot; identifies the source of the current WriteEnable pulse.
- PendingMask  out  16  bit a = a write to register a is held in a slot or in the output stage.

## Operation
- Handshake: a transfer occurs on a rising edge where ReqValid[i] & ReqReady[i] are both high. ReqAddr/ReqData are sampled at that edge.
- ReqReady[i] = ~Reset & (slot i empty | slot i granted this cycle). Drain and refill of the same slot in one cycle is supported.
- r0 filter: a transfer with address 0 completes the handshake but does not fill the slot. No write is issued.
- Arbitration: each cycle, among full slots, grant the first index found searching from pointer P upward, modulo NUM_REQ.
  - On a grant to index i, P <= (i+1) mod NUM_REQ. With no grant, P holds.
- Output stage:
  - With a grant: at the edge, WriteEnable <= 1, WriteAddr/WriteData <= the winner's slot, Grant <= onehot(i).
  - Without a grant: WriteEnable <= 0 and Grant <= 0; WriteAddr and WriteData hold their values.
- Ordering:
  - Writes from one requester reach the register file in acceptance order.
  - Writes from different requesters to the same register land in grant order; last grant wins.
- PendingMask is combinational: OR of decode(slot addr) over full slots, plus decode(WriteAddr) when WriteEnable is high. Bit 0 is always 0.
- Reset (any cycle, including mid-operation):
  - All slots are emptied and queued writes discarded.
  - P = 0.
  - WriteEnable = 0, WriteAddr = 0, WriteData = 0, Grant = 0.
  - ReqReady = 0 and PendingMask = 0 while Reset is high.

## Timing
- Latency: accepted at edge k; granted during cycle k→k+1; WriteEnable high during cycle k+1→k+2; register file captures at edge k+2.
- Throughput: one write per cycle aggregate. Any single requester sustains one write per cycle when it is the only one active.
- Fairness: with all N slots continuously full, each requester is granted exactly once every N cycles.
- Starvation bound: a full slot is granted within NUM_REQ cycles.
- Back-to-back requests from a granted requester incur no bubble, because ready stays high on the drain cycle.
- Read-after-write: decode must stall a consumer while its PendingMask bit is set.
  - The bit clears in the cycle after WriteEnable drops for that address, i.e. once the register file has captured the value.

## Structure
- Shared package merc16_pkg holds:
  - DATA_W = 16, ADDR_W = 4, NUM_REGS = 16, ZERO_REG = 0.
  - Requester index constants REQ_ALU = 0, REQ_LOAD = 1, REQ_DEBUG = 2.
- Sub-module rr_arbiter: inputs request vector and pointer; outputs one-hot grant and a grant-valid flag. It is purely combinational; the pointer register stays in the parent.
- Slots: NUM_REQ instances of {full, addr, data} registers in a generate loop.

## Test plan
- Single write: ALU valid, addr 5, data 0x1234 accepted at edge k → WriteEnable=1, WriteAddr=5, WriteData=0x1234, Grant=001 during cycle k+1; PendingMask[5]=1 until the write completes, then 0.
- Contention: all three valid at once, P=0, addrs 1/2/3 → writes issue in order 1, 2, 3 on consecutive cycles; Grant sequence 001, 010, 100; P ends at 0.
- r0 drop: load writes addr 0, data 0xFFFF → ReqReady=1 and the handshake completes; WriteEnable stays 0; PendingMask stays 0.
- Streaming: ALU valid for 4 consecutive cycles with data 1, 2, 3, 4 to addr 7, others idle → ReqReady stays 1 throughout; four consecutive WriteEnable pulses carry data 1, 2, 3, 4 in order.
- Same-register race: ALU and debug both write addr 9 (0xAAAA, 0x5555) in the same cycle, P=2 → debug is granted first, then ALU; final value is 0xAAAA.
- Reset mid-operation: three full slots, Reset asserted for one cycle → the next edge shows WriteEnable=0 and PendingMask=0; no queued write ever reaches the output; P=0 afterwards.

Source files
------------

// File: rtl/merc16_pkg.sv
// Shared constants for the merc16 register-file write path.
// Also holds the register-address decode helper.
package merc16_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int NUM_REGS  = 16;
  localparam int ZERO_REG  = 0;
  localparam int NUM_REQ   = 3;

  localparam int REQ_ALU   = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_DEBUG = 2;

  function automatic logic [NUM_REGS-1:0] reg_decode(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] dec;
    dec       = {NUM_REGS{1'b0}};
    dec[addr] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter
  import merc16_pkg::*;
#(
  parameter int N     = NUM_REQ,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_gnt_valid
);

  // Walk offsets from the pointer; the first live request wins.
  always_comb begin
    logic found;
    o_gnt = {N{1'b0}};
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && i_req[j] && (j == ((int'(i_ptr) + k) % N))) begin
          o_gnt[j] = 1'b1;
          found    = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  assign o_gnt_valid = |i_req;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among ALU, load and debug writeback.
// One holding slot per requester, round-robin drain into a registered write stage.
module regfile_write_arbiter
  import merc16_pkg::*;
(
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic                      WriteEnable,
  output logic [ADDR_W-1:0]         WriteAddr,
  output logic [DATA_W-1:0]         WriteData,
  output logic [NUM_REQ-1:0]        Grant,
  output logic [NUM_REGS-1:0]       PendingMask
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_full;
  logic [ADDR_W-1:0]  w_slot_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_slot_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_valid;
  logic [NUM_REQ-1:0] w_ready;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_data;
  logic [PTR_W-1:0]   w_win_idx;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [NUM_REGS-1:0] w_pend;

  logic [PTR_W-1:0]   r_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [NUM_REQ-1:0] r_grant;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req       (w_full),
    .i_ptr       (r_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_valid (w_gnt_valid)
  );

  // A slot being drained this cycle can refill in the same cycle.
  assign w_ready = Reset ? {NUM_REQ{1'b0}} : (~w_full | w_gnt);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic               r_full;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [ADDR_W-1:0]  w_in_addr;

    assign w_in_addr = ReqAddr[gi*ADDR_W +: ADDR_W];

    // Slot fill on handshake (r0 writes are swallowed), empty on grant.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        r_full <= 1'b0;
        r_addr <= {ADDR_W{1'b0}};
        r_data <= {DATA_W{1'b0}};
      end else if (ReqValid[gi] && w_ready[gi] && (w_in_addr != ADDR_W'(ZERO_REG))) begin
        r_full <= 1'b1;
        r_addr <= w_in_addr;
        r_data <= ReqData[gi*DATA_W +: DATA_W];
      end else if (w_gnt[gi]) begin
        r_full <= 1'b0;
      end else begin
        r_full <= r_full;
      end
    end

    assign w_full[gi]      = r_full;
    assign w_slot_addr[gi] = r_addr;
    assign w_slot_data[gi] = r_data;
  end

  // One-hot grant selects the winning slot contents and its index.
  always_comb begin
    w_win_addr = {ADDR_W{1'b0}};
    w_win_data = {DATA_W{1'b0}};
    w_win_idx  = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_addr = w_win_addr | (w_slot_addr[i] & {ADDR_W{w_gnt[i]}});
      w_win_data = w_win_data | (w_slot_data[i] & {DATA_W{w_gnt[i]}});
      w_win_idx  = w_win_idx  | (PTR_W'(i) & {PTR_W{w_gnt[i]}});
    end
  end

  // Pointer advances past the winner, wrapping at the last requester.
  always_comb begin
    if (!w_gnt_valid) begin
      w_ptr_next = r_ptr;
    end else if (w_win_idx == PTR_W'(NUM_REQ - 1)) begin
      w_ptr_next = {PTR_W{1'b0}};
    end else begin
      w_ptr_next = w_win_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ptr <= {PTR_W{1'b0}};
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_we    <= 1'b0;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_grant <= {NUM_REQ{1'b0}};
    end else if (w_gnt_valid) begin
      r_we    <= 1'b1;
      r_waddr <= w_win_addr;
      r_wdata <= w_win_data;
      r_grant <= w_gnt;
    end else begin
      r_we    <= 1'b0;
      r_grant <= {NUM_REQ{1'b0}};
    end
  end

  // Registers with a write held in a slot or sitting on the write port.
  always_comb begin
    w_pend = {NUM_REGS{1'b0}};
    if (Reset) begin
      w_pend = {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_pend = w_pend | (w_full[i] ? reg_decode(w_slot_addr[i]) : {NUM_REGS{1'b0}});
      end
      if (r_we) begin
        w_pend = w_pend | reg_decode(r_waddr);
      end else begin
        w_pend = w_pend;
      end
      w_pend[ZERO_REG] = 1'b0;
    end
  end

  assign ReqReady    = w_ready;
  assign WriteEnable = r_we;
  assign WriteAddr   = r_waddr;
  assign WriteData   = r_wdata;
  assign Grant       = r_grant;
  assign PendingMask = w_pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every WriteEnable pulse.
module tb_regfile_write_arbiter;
  import merc16_pkg::*;

  logic                      Clock = 1'b0;
  logic                      Reset;
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]        ReqReady;
  logic                      WriteEnable;
  logic [ADDR_W-1:0]         WriteAddr;
  logic [DATA_W-1:0]         WriteData;
  logic [NUM_REQ-1:0]        Grant;
  logic [NUM_REGS-1:0]       PendingMask;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [NUM_REQ-1:0] grant;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [DATA_W-1:0] tb_rf [NUM_REGS];

  regfile_write_arbiter dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ReqValid    (ReqValid),
    .ReqAddr     (ReqAddr),
    .ReqData     (ReqData),
    .ReqReady    (ReqReady),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .Grant       (Grant),
    .PendingMask (PendingMask)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ReqValid[i] = 1'b1;
    ReqAddr[i*ADDR_W +: ADDR_W] = a;
    ReqData[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    ReqValid = '0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NUM_REQ-1:0] g);
    exp_t e;
    e.addr  = a;
    e.data  = d;
    e.grant = g;
    sbq.push_back(e);
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (WriteEnable === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h grant %0b, expected no write",
                 WriteAddr, WriteData, Grant);
      end else begin
        mon_e = sbq.pop_front();
        check("write_addr", 32'(WriteAddr), 32'(mon_e.addr));
        check("write_data", 32'(WriteData), 32'(mon_e.data));
        check("write_grant", 32'(Grant), 32'(mon_e.grant));
      end
      tb_rf[WriteAddr] = WriteData;
    end else begin
      check("idle_grant", 32'(Grant), 32'd0);
    end
  end

  initial begin
    int waited;
    Reset    = 1'b1;
    ReqValid = '0;
    ReqAddr  = '0;
    ReqData  = '0;
    for (int r = 0; r < NUM_REGS; r++) tb_rf[r] = 16'h0000;

    // Reset state
    step();
    #1;
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_pend", 32'(PendingMask), 32'd0);
    check("rst_we", 32'(WriteEnable), 32'd0);
    check("rst_waddr", 32'(WriteAddr), 32'd0);
    check("rst_wdata", 32'(WriteData), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    Reset = 1'b0;
    step();

    // Contention from P=0: grants 001, 010, 100; P returns to 0
    set_req(REQ_ALU, 4'd1, 16'h0101);
    set_req(REQ_LOAD, 4'd2, 16'h0202);
    set_req(REQ_DEBUG, 4'd3, 16'h0303);
    push(4'd1, 16'h0101, 3'b001);
    push(4'd2, 16'h0202, 3'b010);
    push(4'd3, 16'h0303, 3'b100);
    #1;
    check("cont_ready", 32'(ReqReady), 32'b111);
    step();
    idle();
    #1;
    check("cont_pend0", 32'(PendingMask), 32'h000E);
    step();
    check("cont_pend1", 32'(PendingMask), 32'h000E);
    step();
    check("cont_pend2", 32'(PendingMask), 32'h000C);
    step();
    check("cont_pend3", 32'(PendingMask), 32'h0008);
    step();
    check("cont_pend4", 32'(PendingMask), 32'h0000);

    // Single ALU write to r5
    set_req(REQ_ALU, 4'd5, 16'h1234);
    push(4'd5, 16'h1234, 3'b001);
    step();
    idle();
    check("single_pend_slot", 32'(PendingMask), 32'h0020);
    check("single_we_lat", 32'(WriteEnable), 32'd0);
    step();
    check("single_we", 32'(WriteEnable), 32'd1);
    check("single_pend_out", 32'(PendingMask), 32'h0020);
    step();
    check("single_we_off", 32'(WriteEnable), 32'd0);
    check("single_pend_clr", 32'(PendingMask), 32'h0000);

    // r0 drop from load port
    set_req(REQ_LOAD, 4'd0, 16'hFFFF);
    #1;
    check("r0_ready", 32'(ReqReady), 32'b111);
    step();
    idle();
    check("r0_pend", 32'(PendingMask), 32'h0000);
    step();
    check("r0_we", 32'(WriteEnable), 32'd0);
    check("r0_pend2", 32'(PendingMask), 32'h0000);

    // Streaming ALU writes to r7 without bubbles
    for (int i = 0; i < 4; i++) begin
      set_req(REQ_ALU, 4'd7, 16'(i + 1));
      push(4'd7, 16'(i + 1), 3'b001);
      #1;
      check("stream_ready", 32'(ReqReady[REQ_ALU]), 32'd1);
      step();
      if (i > 0) check("stream_we", 32'(WriteEnable), 32'd1);
    end
    idle();
    step();
    check("stream_we_last", 32'(WriteEnable), 32'd1);
    step();
    check("stream_we_off", 32'(WriteEnable), 32'd0);
    check("stream_rf7", 32'(tb_rf[7]), 32'd4);

    // Load write moves P to 2
    set_req(REQ_LOAD, 4'd4, 16'h4444);
    push(4'd4, 16'h4444, 3'b010);
    step();
    idle();
    step();
    step();

    // Same-register race with P=2: debug first, ALU last
    set_req(REQ_ALU, 4'd9, 16'hAAAA);
    set_req(REQ_DEBUG, 4'd9, 16'h5555);
    push(4'd9, 16'h5555, 3'b100);
    push(4'd9, 16'hAAAA, 3'b001);
    step();
    idle();
    check("race_pend", 32'(PendingMask), 32'h0200);
    step();
    step();
    step();
    check("race_rf9", 32'(tb_rf[9]), 32'hAAAA);
    check("race_pend_clr", 32'(PendingMask), 32'h0000);

    // Reset with all three slots full: queued writes are discarded
    set_req(REQ_ALU, 4'd10, 16'h0A0A);
    set_req(REQ_LOAD, 4'd11, 16'h0B0B);
    set_req(REQ_DEBUG, 4'd12, 16'h0C0C);
    step();
    idle();
    check("midrst_pend_full", 32'(PendingMask), 32'h1C00);
    Reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ReqReady), 32'd0);
    check("midrst_pend", 32'(PendingMask), 32'd0);
    step();
    Reset = 1'b0;
    #1;
    check("midrst_we", 32'(WriteEnable), 32'd0);
    check("midrst_pend_after", 32'(PendingMask), 32'd0);
    step();
    check("midrst_we2", 32'(WriteEnable), 32'd0);
    step();

    // P must be 0 after reset: order 001, 010, 100
    set_req(REQ_ALU, 4'd13, 16'hD0D0);
    set_req(REQ_LOAD, 4'd14, 16'hE0E0);
    set_req(REQ_DEBUG, 4'd15, 16'hF0F0);
    push(4'd13, 16'hD0D0, 3'b001);
    push(4'd14, 16'hE0E0, 3'b010);
    push(4'd15, 16'hF0F0, 3'b100);
    step();
    idle();

    waited = 0;
    while (sbq.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    step();
    check("drain_remaining", 32'(sbq.size()), 32'd0);
    check("final_we", 32'(WriteEnable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
